// File: rtl/m_fft_pkg.sv
// Shared constants, state encoding and index mapping for the 8-point FFT
// datapath. Reused by the loader, butterfly and output stages.
package m_fft_pkg;

    localparam int N_PTS = 8;
    localparam int AW    = 3;

    typedef enum logic [1:0] {
        FILL,
        FLUSH,
        SETTLE,
        READY
    } state_t;

    // 3-bit bit reversal: sample index -> register-file address
    function automatic logic [AW-1:0] bitrev3(input logic [AW-1:0] n);
        return {n[0], n[1], n[2]};
    endfunction

endpackage

// File: rtl/m_fft_loader.sv
// Upstream loader for the 8-entry complex-sample register file feeding the
// 8-point FFT. Accepts a valid/ready stream of {real, imag} samples, writes
// each group of 8 into the register file (bit-reversed addresses by default),
// and raises frame_valid once the register file's registered outputs hold the
// complete frame. Input is stalled until the FFT core acknowledges the frame.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   s_valid      - input sample valid
//   s_ready      - loader can accept a sample (combinational, FILL only)
//   s_data       - input sample, real in [2*DW-1:DW], imag in [DW-1:0]
//   ram_addr     - register-file write address
//   ram_data     - register-file write data
//   ram_we       - register-file write enable
//   frame_valid  - complete frame visible on register-file outputs
//   frame_ack    - FFT core has consumed the frame
//   frame_id     - wrapping count of completed frames
module m_fft_loader
    import m_fft_pkg::*;
#(
    parameter int          DW      = 32,
    parameter int unsigned BIT_REV = 1,
    parameter int          FID_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [2*DW-1:0]   s_data,
    output logic [AW-1:0]     ram_addr,
    output logic [2*DW-1:0]   ram_data,
    output logic              ram_we,
    output logic              frame_valid,
    input  logic              frame_ack,
    output logic [FID_W-1:0]  frame_id
);

    state_t              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic                ram_we_q, ram_we_d;
    logic [AW-1:0]       ram_addr_q, ram_addr_d;
    logic [2*DW-1:0]     ram_data_q, ram_data_d;
    logic                frame_valid_q, frame_valid_d;
    logic [FID_W-1:0]    frame_id_q, frame_id_d;
    logic                accept;

    assign s_ready = (state_q == FILL) && !rst;
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ram_we_d      = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_data_d    = ram_data_q;
        frame_valid_d = frame_valid_q;
        frame_id_d    = frame_id_q;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = (BIT_REV != 0) ? bitrev3(cnt_q) : cnt_q;
                    ram_data_d = s_data;
                    cnt_d      = cnt_q + AW'(1);  // wraps to 0 after the 8th sample
                    if (cnt_q == AW'(N_PTS - 1)) begin
                        state_d = FLUSH;
                    end
                end
            end
            // Last write is on the register-file port this cycle.
            FLUSH: begin
                state_d = SETTLE;
            end
            // Register file captures its outputs; frame is visible next edge.
            SETTLE: begin
                state_d       = READY;
                frame_valid_d = 1'b1;
                frame_id_d    = frame_id_q + FID_W'(1);
            end
            READY: begin
                if (frame_ack) begin
                    state_d       = FILL;
                    frame_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FILL;
            cnt_q         <= '0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_data_q    <= '0;
            frame_valid_q <= 1'b0;
            frame_id_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_q    <= ram_data_d;
            frame_valid_q <= frame_valid_d;
            frame_id_q    <= frame_id_d;
        end
    end

    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_data    = ram_data_q;
    assign frame_valid = frame_valid_q;
    assign frame_id    = frame_id_q;

endmodule

// File: tb/tb_m_fft_loader.sv
module tb_m_fft_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [63:0] s_data = '0;
    logic        frame_ack = 1'b0;

    logic        s_ready, ram_we, frame_valid;
    logic [2:0]  ram_addr;
    logic [63:0] ram_data;
    logic [7:0]  frame_id;

    logic        s_ready0, ram_we0, frame_valid0;
    logic [2:0]  ram_addr0;
    logic [63:0] ram_data0;
    logic [7:0]  frame_id0;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    int          wlog_a[$];
    logic [63:0] wlog_d[$];
    int          wlog_c[$];
    int          w0log_a[$];

    logic [63:0] rf_mem [8];
    logic [63:0] rf_out [8];

    int rev_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    m_fft_loader #(.DW(32), .BIT_REV(1), .FID_W(8)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_we(ram_we), .frame_valid(frame_valid), .frame_ack(frame_ack),
        .frame_id(frame_id)
    );

    m_fft_loader #(.DW(32), .BIT_REV(0), .FID_W(8)) dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0),
        .s_data(s_data), .ram_addr(ram_addr0), .ram_data(ram_data0),
        .ram_we(ram_we0), .frame_valid(frame_valid0), .frame_ack(frame_ack),
        .frame_id(frame_id0)
    );

    always #5 clk = ~clk;

    // Downstream register file: write port plus registered outputs.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) rf_mem[ram_addr] <= ram_data;
        for (int i = 0; i < 8; i++) rf_out[i] <= rf_mem[i];
    end

    always @(negedge clk) begin
        if (ram_we) begin
            wlog_a.push_back(int'(ram_addr));
            wlog_d.push_back(ram_data);
            wlog_c.push_back(cyc);
        end
        if (ram_we0) w0log_a.push_back(int'(ram_addr0));
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] samp(input int n);
        logic [63:0] unit;
        unit = 64'h00000001_00000010;
        return unit * 64'(n + 1);
    endfunction

    // Offer nsamp samples; gappy uses valid pattern 1,0,0,1,0,0...
    task automatic stream(input int nsamp, input bit gappy, input int ack_at);
        int n;
        int t;
        n = 0;
        t = 0;
        while (n < nsamp) begin
            @(negedge clk);
            s_valid   = !gappy || (t % 3 == 0);
            s_data    = samp(n);
            frame_ack = (t == ack_at);
            if (s_valid && s_ready) n++;
            t++;
            if (t > 200) begin
                chk("stream_timeout", 64'(n), 64'(nsamp));
                break;
            end
        end
    endtask

    // Called right after the last accept has been driven (edge E is next).
    task automatic post_frame(input bit ack_settle, input bit full_chk, input bit gappy);
        @(negedge clk);
        frame_ack = 1'b0;
        chk("fv_after_E", 64'(frame_valid), 64'd0);
        @(negedge clk);
        chk("fv_after_E1", 64'(frame_valid), 64'd0);
        frame_ack = ack_settle;
        @(negedge clk);
        frame_ack = 1'b0;
        chk("fv_after_E2", 64'(frame_valid), 64'd1);
        if (ack_settle) begin
            @(negedge clk);
            chk("fv_settle_ack_ignored", 64'(frame_valid), 64'd1);
        end
        if (full_chk) begin
            chk("n_writes", 64'(wlog_a.size()), 64'd8);
            if (wlog_a.size() == 8) begin
                for (int i = 0; i < 8; i++) begin
                    chk($sformatf("addr%0d", i), 64'(wlog_a[i]), 64'(rev_tab[i]));
                    chk($sformatf("data%0d", i), wlog_d[i], samp(i));
                end
                if (!gappy) chk("we_consecutive", 64'(wlog_c[7] - wlog_c[0]), 64'd7);
            end
            chk("data04r", {32'd0, rf_out[4][63:32]}, 64'h2);
            chk("data04i", {32'd0, rf_out[4][31:0]}, 64'h20);
        end
    endtask

    // One-cycle ack; s_valid left as is so the ack cycle must not accept.
    task automatic do_ack();
        @(negedge clk);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        chk("ack_fv", 64'(frame_valid), 64'd0);
        chk("ack_ready", 64'(s_ready), 64'd1);
        chk("ack_no_we", 64'(ram_we), 64'd0);
        s_valid = 1'b0;
    endtask

    initial begin
        int bad;
        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready_low", 64'(s_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_we", 64'(ram_we), 64'd0);
        chk("rst_addr", 64'(ram_addr), 64'd0);
        chk("rst_data", ram_data, 64'd0);
        chk("rst_fv", 64'(frame_valid), 64'd0);
        chk("rst_fid", 64'(frame_id), 64'd0);
        chk("rst_ready", 64'(s_ready), 64'd1);

        // Frame 1: continuous stream
        wlog_a.delete(); wlog_d.delete(); wlog_c.delete();
        stream(8, 1'b0, -1);
        post_frame(1'b0, 1'b1, 1'b0);
        chk("fid_1", 64'(frame_id), 64'd1);

        // Hold without ack, s_valid high
        s_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_ready || ram_we || !frame_valid) bad++;
        end
        chk("hold_bad_cycles", 64'(bad), 64'd0);
        do_ack();

        // Gappy frame with acks during FILL and SETTLE
        wlog_a.delete(); wlog_d.delete(); wlog_c.delete();
        stream(8, 1'b1, 2);
        post_frame(1'b1, 1'b1, 1'b1);
        chk("fid_2", 64'(frame_id), 64'd2);
        do_ack();

        // Reset after 5 accepts, then a fresh frame
        stream(5, 1'b0, -1);
        @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", 64'(s_ready), 64'd0);
        chk("mid_rst_we", 64'(ram_we), 64'd0);
        chk("mid_rst_fid", 64'(frame_id), 64'd0);
        chk("mid_rst_fv", 64'(frame_valid), 64'd0);
        rst = 1'b0;
        wlog_a.delete(); wlog_d.delete(); wlog_c.delete();
        stream(8, 1'b0, -1);
        post_frame(1'b0, 1'b1, 1'b0);
        chk("post_rst_first_addr", 64'(wlog_a.size() > 0 ? wlog_a[0] : -1), 64'd0);
        chk("post_rst_fid", 64'(frame_id), 64'd1);
        do_ack();

        // Frame-id wrap with immediate ack
        for (int k = 0; k < 254; k++) begin
            stream(8, 1'b0, -1);
            post_frame(1'b0, 1'b0, 1'b0);
            do_ack();
        end
        chk("fid_255", 64'(frame_id), 64'd255);
        w0log_a.delete();
        stream(8, 1'b0, -1);
        post_frame(1'b0, 1'b0, 1'b0);
        chk("fid_wrap", 64'(frame_id), 64'd0);
        chk("lin_n_writes", 64'(w0log_a.size()), 64'd8);
        if (w0log_a.size() == 8)
            for (int i = 0; i < 8; i++)
                chk($sformatf("lin_addr%0d", i), 64'(w0log_a[i]), 64'(i));
        chk("lin_fv", 64'(frame_valid0), 64'd1);
        do_ack();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/m_fft_loader.md
Name: m_fft_loader

Overview:
- Upstream loader for the 8-entry complex-sample register file that feeds the 8-point FFT datapath.
- Accepts a valid/ready stream of 64-bit complex samples, with real in [63:32] and imag in [31:0].
- Writes each group of 8 samples into the register file, in bit-reversed address order by default.
- Once the register file's registered outputs reflect the complete frame, raises frame_valid. It then holds off input until the FFT core acknowledges the frame.

Parameters:
- DW, 32: width of each real/imag component; sample width is 2*DW.
- BIT_REV, 1: 1 = write sample n to address bitrev3(n); 0 = write sample n to address n.
- FID_W, 8: width of the wrapping frame counter.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  input sample valid
- s_ready  out  1  loader can accept a sample
- s_data  in  2*DW  input sample, real in upper half, imag in lower half
- ram_addr  out  3  register-file write address
- ram_data  out  2*DW  register-file write data
- ram_we  out  1  register-file write enable
- frame_valid  out  1  complete frame visible on register-file outputs
- frame_ack  in  1  FFT core has consumed the frame
- frame_id  out  FID_W  count of completed frames, wrapping

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset values:
  - state = FILL, cnt = 0
  - ram_we = 0, ram_addr = 0, ram_data = 0
  - frame_valid = 0, frame_id = 0
  - s_ready = 1 in the first cycle after reset is released.
- States:
  - FILL: s_ready = 1. Each edge with s_valid & s_ready accepts a sample.
  - FLUSH: last write in flight.
  - SETTLE: register file is capturing its outputs.
  - READY: frame_valid = 1.
- s_ready is combinational: (state == FILL). It is 0 while rst is high.
- Accept at edge k, with cnt = n:
  - registered outputs go to ram_we = 1, ram_addr = (BIT_REV ? {n[0],n[1],n[2]} : n), ram_data = s_data;
  - cnt increments.
  - If no accept, ram_we = 0; ram_addr and ram_data hold.
- BIT_REV = 1 mapping (sample index -> address): 0->0, 1->4, 2->2, 3->6, 4->1, 5->5, 6->3, 7->7.
- Accept of the 8th sample (cnt = 7) at edge E:
  - state -> FLUSH, cnt wraps to 0.
  - Edge E+1: register file writes; state -> SETTLE; ram_we = 0.
  - Edge E+2: register-file outputs now hold the frame; state -> READY, frame_valid = 1, frame_id increments (wraps at 2^FID_W).
- READY:
  - s_ready = 0; input stream stalls.
  - frame_valid stays high until frame_ack = 1 is sampled.
  - Next edge: state -> FILL, frame_valid = 0, s_ready = 1.
- No sample is accepted in the ack cycle. The earliest next accept is the cycle after ack.
- frame_ack in FILL, FLUSH or SETTLE is ignored and is not remembered.
- s_valid gaps in FILL: cnt holds, no writes; there is no timeout.
- Reset mid-fill, or in any state:
  - partial frame discarded; cnt = 0, state = FILL, ram_we = 0, frame_valid = 0, frame_id = 0.
  - Register-file contents are not cleared; stale entries are overwritten by the next frame.
- Write data is never modified: no scaling, no sign handling.
- Sustained throughput: 8 samples per (8 + 3 + ack latency) cycles.

Decomposition:
- Shared package m_fft_pkg:
  - constants N_PTS = 8, AW = 3;
  - state enum {FILL, FLUSH, SETTLE, READY};
  - function bitrev3.
- Package is reused by the butterfly and output stages for index mapping.
- No sub-module; the loader is a single FSM plus counter.

Test Plan:
- Reset then stream 8 samples, 0x00000001_00000010 * (n+1), n = 0..7, s_valid held high, BIT_REV = 1:
  - ram_addr sequence is 0, 4, 2, 6, 1, 5, 3, 7 with ram_we = 1 for 8 consecutive cycles;
  - frame_valid rises 2 edges after the last accept;
  - register-file outputs data04r/data04i = 0x00000002/0x00000020 (sample 1 at address 4);
  - frame_id = 1.
- Hold frame_ack = 0 for 20 cycles with s_valid = 1:
  - s_ready = 0 and no ram_we throughout; frame_valid stays 1.
  - Assert frame_ack for 1 cycle: frame_valid = 0 and s_ready = 1 on the next cycle.
- Toggle s_valid 1,0,0,1,... across a frame:
  - exactly 8 writes, addresses still in bit-reversed order;
  - frame_valid only after the 8th accept + 2 edges.
- Assert rst after 5 accepts, then send a fresh 8 samples:
  - the first post-reset write goes to address 0;
  - frame_valid follows only the fresh 8 samples; frame_id = 1.
- Pulse frame_ack during FILL and SETTLE: no state change; frame_valid still asserts normally.
- Run 256 frames with immediate ack: frame_id wraps 255 -> 0. Repeat one frame with BIT_REV = 0: addresses 0..7 in order.
